// File: rtl/datapath_core_if.sv
// datapath_core_if
// Control and observation bundle for datapath_core.
//   Load strobes   : pc_in, ir_in, mar_in, mdr_in, y_in, zlow_in, zhigh_in, r_in
//   Bus selects    : pc_out, mdr_out, zlow_out, csign_out, r_out, ba_out
//   Register select: gra (IR[26:23]), grb (IR[22:19])
//   ALU ops        : op_add, op_and, op_or, inc_pc
//   Memory control : read, write, md_read, mar_clear
//   RAM preload    : prog_we, prog_addr, prog_data (simulation loader port)
//   Observation    : bus_mux_out (internal bus value)
// The master modport drives the controls; the slave modport is the datapath.

interface datapath_core_if;
    logic        pc_in;
    logic        ir_in;
    logic        mar_in;
    logic        mdr_in;
    logic        y_in;
    logic        zlow_in;
    logic        zhigh_in;
    logic        r_in;

    logic        pc_out;
    logic        mdr_out;
    logic        zlow_out;
    logic        csign_out;
    logic        r_out;
    logic        ba_out;

    logic        gra;
    logic        grb;

    logic        op_add;
    logic        op_and;
    logic        op_or;
    logic        inc_pc;

    logic        read;
    logic        write;
    logic        md_read;
    logic        mar_clear;

    logic        prog_we;
    logic [8:0]  prog_addr;
    logic [31:0] prog_data;

    logic [31:0] bus_mux_out;

    modport master (
        output pc_in, ir_in, mar_in, mdr_in, y_in, zlow_in, zhigh_in, r_in,
        output pc_out, mdr_out, zlow_out, csign_out, r_out, ba_out,
        output gra, grb,
        output op_add, op_and, op_or, inc_pc,
        output read, write, md_read, mar_clear,
        output prog_we, prog_addr, prog_data,
        input  bus_mux_out
    );

    modport slave (
        input  pc_in, ir_in, mar_in, mdr_in, y_in, zlow_in, zhigh_in, r_in,
        input  pc_out, mdr_out, zlow_out, csign_out, r_out, ba_out,
        input  gra, grb,
        input  op_add, op_and, op_or, inc_pc,
        input  read, write, md_read, mar_clear,
        input  prog_we, prog_addr, prog_data,
        output bus_mux_out
    );
endinterface

// File: rtl/datapath_core.sv
// datapath_core
// Single-bus CPU datapath: sixteen general registers, PC, IR, MAR, MDR,
// Y, Zlow/Zhigh, the Mdatain memory staging register and a 512 x 32
// synchronous RAM addressed by MAR.
// Ports:
//   clk  - rising-edge clock for all state
//   rst  - asynchronous active-high clear of every register (RAM untouched)
//   ctrl - datapath_core_if.slave: load strobes, bus selects, register
//          selects, ALU ops, memory controls, RAM preload port and the
//          observed bus value.

module datapath_core (
    input  logic             clk,
    input  logic             rst,
    datapath_core_if.slave   ctrl
);

    logic [31:0] regs [16];
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] mdr;
    logic [31:0] y;
    logic [31:0] zlow;
    logic [31:0] zhigh;
    logic [31:0] mdatain;
    logic [8:0]  mar;

    logic [31:0] ram [512];

    logic [3:0]  reg_index;
    logic [31:0] c_sign;
    logic [31:0] bus;
    logic [32:0] sum;
    logic [31:0] alu_low;
    logic [31:0] alu_high;

    // Gra wins over Grb; with neither asserted the index falls back to R0.
    always_comb begin
        reg_index = 4'd0;
        if (ctrl.gra) begin
            reg_index = ir[26:23];
        end else if (ctrl.grb) begin
            reg_index = ir[22:19];
        end
    end

    assign c_sign = {{13{ir[18]}}, ir[18:0]};

    // Fixed-priority bus mux. BAout treats R0 as a hard zero for base
    // addressing, while Rout reads R0 as an ordinary register.
    always_comb begin
        bus = 32'd0;
        if (ctrl.zlow_out) begin
            bus = zlow;
        end else if (ctrl.mdr_out) begin
            bus = mdr;
        end else if (ctrl.pc_out) begin
            bus = pc;
        end else if (ctrl.csign_out) begin
            bus = c_sign;
        end else if (ctrl.r_out) begin
            bus = regs[reg_index];
        end else if (ctrl.ba_out) begin
            bus = (reg_index == 4'd0) ? 32'd0 : regs[reg_index];
        end
    end

    assign ctrl.bus_mux_out = bus;

    // The carry out of the 33-bit add becomes the whole high word.
    assign sum = {1'b0, y} + {1'b0, bus};

    always_comb begin
        alu_low  = 32'd0;
        alu_high = 32'd0;
        if (ctrl.inc_pc) begin
            alu_low = bus + 32'd1;
        end else if (ctrl.op_add) begin
            alu_low  = sum[31:0];
            alu_high = {31'd0, sum[32]};
        end else if (ctrl.op_and) begin
            alu_low = y & bus;
        end else if (ctrl.op_or) begin
            alu_low = y | bus;
        end
    end

    // All register loads sample the pre-edge bus, so a register may be the
    // bus source and the destination in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) begin
                regs[i] <= 32'd0;
            end
            pc      <= 32'd0;
            ir      <= 32'd0;
            mdr     <= 32'd0;
            y       <= 32'd0;
            zlow    <= 32'd0;
            zhigh   <= 32'd0;
            mdatain <= 32'd0;
            mar     <= 9'd0;
        end else begin
            if (ctrl.pc_in) begin
                pc <= bus;
            end
            if (ctrl.ir_in) begin
                ir <= bus;
            end
            if (ctrl.y_in) begin
                y <= bus;
            end
            if (ctrl.zlow_in) begin
                zlow <= alu_low;
            end
            if (ctrl.zhigh_in) begin
                zhigh <= alu_high;
            end
            if (ctrl.r_in) begin
                regs[reg_index] <= bus;
            end
            if (ctrl.mar_clear) begin
                mar <= 9'd0;
            end else if (ctrl.mar_in) begin
                mar <= bus[8:0];
            end
            // Reading the array here gives read-before-write when Read and
            // Write hit the same address in one cycle.
            if (ctrl.read) begin
                mdatain <= ram[mar];
            end
            if (ctrl.mdr_in) begin
                mdr <= ctrl.md_read ? mdatain : bus;
            end
        end
    end

    // RAM has no reset. Datapath writes are held off while clear is high;
    // the preload port stays usable so memory can be filled during clear.
    always_ff @(posedge clk) begin
        if (!rst && ctrl.write) begin
            ram[mar] <= mdr;
        end
        if (ctrl.prog_we) begin
            ram[ctrl.prog_addr] <= ctrl.prog_data;
        end
    end

endmodule

// File: tb/tb_datapath_core.sv
// tb_datapath_core
// Directed bench for datapath_core. Expected values are pushed onto a
// scoreboard queue as each check is set up and popped when the observed
// value (bus, or an internal register with no bus path) is sampled.

module tb_datapath_core;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    datapath_core_if ctrl_if ();

    datapath_core dut (
        .clk  (clk),
        .rst  (rst),
        .ctrl (ctrl_if)
    );

    typedef struct {
        string       tag;
        logic [31:0] value;
    } expect_t;

    expect_t scoreboard[$];
    int testsRun    = 0;
    int testsFailed = 0;

    task automatic clearControls();
        ctrl_if.pc_in     = 1'b0;
        ctrl_if.ir_in     = 1'b0;
        ctrl_if.mar_in    = 1'b0;
        ctrl_if.mdr_in    = 1'b0;
        ctrl_if.y_in      = 1'b0;
        ctrl_if.zlow_in   = 1'b0;
        ctrl_if.zhigh_in  = 1'b0;
        ctrl_if.r_in      = 1'b0;
        ctrl_if.pc_out    = 1'b0;
        ctrl_if.mdr_out   = 1'b0;
        ctrl_if.zlow_out  = 1'b0;
        ctrl_if.csign_out = 1'b0;
        ctrl_if.r_out     = 1'b0;
        ctrl_if.ba_out    = 1'b0;
        ctrl_if.gra       = 1'b0;
        ctrl_if.grb       = 1'b0;
        ctrl_if.op_add    = 1'b0;
        ctrl_if.op_and    = 1'b0;
        ctrl_if.op_or     = 1'b0;
        ctrl_if.inc_pc    = 1'b0;
        ctrl_if.read      = 1'b0;
        ctrl_if.write     = 1'b0;
        ctrl_if.md_read   = 1'b0;
        ctrl_if.mar_clear = 1'b0;
        ctrl_if.prog_we   = 1'b0;
        ctrl_if.prog_addr = 9'd0;
        ctrl_if.prog_data = 32'd0;
    endtask

    // Clock one rising edge with the controls currently driven, then drop them.
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        clearControls();
    endtask

    task automatic expectValue(input string tag, input logic [31:0] value);
        expect_t e;
        e.tag   = tag;
        e.value = value;
        scoreboard.push_back(e);
    endtask

    task automatic checkOutput(input logic [31:0] observed);
        expect_t e;
        testsRun++;
        if (scoreboard.size() == 0) begin
            testsFailed++;
            $error("FAIL scoreboard_underflow observed=%h expected=none", observed);
        end else begin
            e = scoreboard.pop_front();
            assert (observed === e.value) else begin
                testsFailed++;
                $error("FAIL %s observed=%h expected=%h", e.tag, observed, e.value);
            end
        end
    endtask

    // Caller drives the bus selects first; sample after the mux settles.
    task automatic sampleBus();
        #2;
        checkOutput(ctrl_if.bus_mux_out);
        clearControls();
    endtask

    // Route a value into MDR through RAM word 0: preload, Read, MD_read+MDRin.
    task automatic loadMdr(input logic [31:0] value);
        ctrl_if.prog_we   = 1'b1;
        ctrl_if.prog_addr = 9'd0;
        ctrl_if.prog_data = value;
        ctrl_if.mar_clear = 1'b1;
        applyStimulus();
        ctrl_if.read = 1'b1;
        applyStimulus();
        ctrl_if.md_read = 1'b1;
        ctrl_if.mdr_in  = 1'b1;
        applyStimulus();
    endtask

    task automatic fetch();
        ctrl_if.pc_out  = 1'b1;
        ctrl_if.inc_pc  = 1'b1;
        ctrl_if.zlow_in = 1'b1;
        ctrl_if.mar_in  = 1'b1;
        applyStimulus();
        ctrl_if.zlow_out = 1'b1;
        ctrl_if.pc_in    = 1'b1;
        ctrl_if.read     = 1'b1;
        applyStimulus();
        ctrl_if.md_read = 1'b1;
        ctrl_if.mdr_in  = 1'b1;
        applyStimulus();
        ctrl_if.mdr_out = 1'b1;
        ctrl_if.ir_in   = 1'b1;
        applyStimulus();
    endtask

    initial begin
        logic [31:0] rndA;
        logic [31:0] rndB;

        clearControls();
        rst = 1'b1;

        // RAM[1] is loaded during clear and must survive later clears.
        ctrl_if.prog_we   = 1'b1;
        ctrl_if.prog_addr = 9'd1;
        ctrl_if.prog_data = 32'h4990_0003;
        applyStimulus();
        expectValue("reset_idle_bus", 32'd0);
        sampleBus();
        rst = 1'b0;
        applyStimulus();

        // Fill registers with random data, then pulse clear between edges.
        rndA = $urandom() | 32'h1;
        rndB = $urandom() | 32'h1;
        loadMdr(rndA);
        ctrl_if.mdr_out = 1'b1;
        ctrl_if.pc_in   = 1'b1;
        ctrl_if.ir_in   = 1'b1;
        ctrl_if.y_in    = 1'b1;
        ctrl_if.r_in    = 1'b1;
        ctrl_if.mar_in  = 1'b1;
        applyStimulus();
        ctrl_if.mdr_out = 1'b1;
        ctrl_if.gra     = 1'b1;
        ctrl_if.r_in    = 1'b1;
        applyStimulus();
        loadMdr(rndB);
        ctrl_if.mdr_out  = 1'b1;
        ctrl_if.op_add   = 1'b1;
        ctrl_if.zlow_in  = 1'b1;
        ctrl_if.zhigh_in = 1'b1;
        applyStimulus();
        expectValue("pre_clear_mdr", rndB);
        ctrl_if.mdr_out = 1'b1;
        sampleBus();

        #1 rst = 1'b1;
        #1 rst = 1'b0;
        expectValue("clear_idle_bus", 32'd0);
        sampleBus();
        expectValue("clear_zlow", 32'd0);
        ctrl_if.zlow_out = 1'b1;
        sampleBus();
        expectValue("clear_mdr", 32'd0);
        ctrl_if.mdr_out = 1'b1;
        sampleBus();
        expectValue("clear_pc", 32'd0);
        ctrl_if.pc_out = 1'b1;
        sampleBus();
        expectValue("clear_csign", 32'd0);
        ctrl_if.csign_out = 1'b1;
        sampleBus();
        expectValue("clear_r0", 32'd0);
        ctrl_if.r_out = 1'b1;
        sampleBus();
        expectValue("clear_ir", 32'd0);
        checkOutput(dut.ir);
        expectValue("clear_zhigh", 32'd0);
        checkOutput(dut.zhigh);
        ctrl_if.md_read = 1'b1;
        ctrl_if.mdr_in  = 1'b1;
        applyStimulus();
        expectValue("clear_mdatain", 32'd0);
        ctrl_if.mdr_out = 1'b1;
        sampleBus();

        // Fetch of 0x41000005 from RAM[0].
        ctrl_if.prog_we   = 1'b1;
        ctrl_if.prog_addr = 9'd0;
        ctrl_if.prog_data = 32'h4100_0005;
        ctrl_if.mar_clear = 1'b1;
        applyStimulus();
        fetch();
        expectValue("fetch_pc", 32'd1);
        ctrl_if.pc_out = 1'b1;
        sampleBus();
        expectValue("fetch_ir", 32'h4100_0005);
        checkOutput(dut.ir);

        // addi: R2 = R0(base) + 5.
        ctrl_if.grb    = 1'b1;
        ctrl_if.ba_out = 1'b1;
        ctrl_if.y_in   = 1'b1;
        applyStimulus();
        ctrl_if.csign_out = 1'b1;
        ctrl_if.op_add    = 1'b1;
        ctrl_if.zlow_in   = 1'b1;
        applyStimulus();
        ctrl_if.zlow_out = 1'b1;
        ctrl_if.gra      = 1'b1;
        ctrl_if.r_in     = 1'b1;
        applyStimulus();
        expectValue("addi_r2", 32'h0000_0005);
        ctrl_if.gra   = 1'b1;
        ctrl_if.r_out = 1'b1;
        sampleBus();

        // andi: refetch from RAM[1], R3 = R2 & 3.
        fetch();
        ctrl_if.grb   = 1'b1;
        ctrl_if.r_out = 1'b1;
        ctrl_if.y_in  = 1'b1;
        applyStimulus();
        ctrl_if.csign_out = 1'b1;
        ctrl_if.op_and    = 1'b1;
        ctrl_if.zlow_in   = 1'b1;
        applyStimulus();
        ctrl_if.zlow_out = 1'b1;
        ctrl_if.gra      = 1'b1;
        ctrl_if.r_in     = 1'b1;
        applyStimulus();
        expectValue("andi_pc", 32'd2);
        ctrl_if.pc_out = 1'b1;
        sampleBus();
        expectValue("andi_r3", 32'h0000_0001);
        ctrl_if.gra   = 1'b1;
        ctrl_if.r_out = 1'b1;
        sampleBus();

        // Priorities: Zlowout over MDRout; IncPC over ADD; AND over OR.
        expectValue("bus_priority", 32'h0000_0001);
        ctrl_if.zlow_out = 1'b1;
        ctrl_if.mdr_out  = 1'b1;
        sampleBus();
        ctrl_if.pc_out  = 1'b1;
        ctrl_if.inc_pc  = 1'b1;
        ctrl_if.op_add  = 1'b1;
        ctrl_if.zlow_in = 1'b1;
        applyStimulus();
        expectValue("alu_incpc_priority", 32'd3);
        ctrl_if.zlow_out = 1'b1;
        sampleBus();
        ctrl_if.pc_out  = 1'b1;
        ctrl_if.op_and  = 1'b1;
        ctrl_if.op_or   = 1'b1;
        ctrl_if.zlow_in = 1'b1;
        applyStimulus();
        expectValue("alu_and_priority", 32'd0);
        ctrl_if.zlow_out = 1'b1;
        sampleBus();

        // Write path: MAR=7 via C, store MDR, clear MDR, read it back.
        loadMdr(32'd7);
        ctrl_if.mdr_out = 1'b1;
        ctrl_if.ir_in   = 1'b1;
        applyStimulus();
        loadMdr(32'hDEAD_BEEF);
        ctrl_if.csign_out = 1'b1;
        ctrl_if.mar_in    = 1'b1;
        ctrl_if.prog_we   = 1'b1;
        ctrl_if.prog_addr = 9'd0;
        ctrl_if.prog_data = 32'd0;
        applyStimulus();
        ctrl_if.write = 1'b1;
        applyStimulus();
        ctrl_if.mdr_in = 1'b1;
        applyStimulus();
        expectValue("mdr_from_idle_bus", 32'd0);
        ctrl_if.mdr_out = 1'b1;
        sampleBus();
        ctrl_if.read = 1'b1;
        applyStimulus();
        ctrl_if.md_read = 1'b1;
        ctrl_if.mdr_in  = 1'b1;
        applyStimulus();
        expectValue("write_readback", 32'hDEAD_BEEF);
        ctrl_if.mdr_out = 1'b1;
        sampleBus();

        // Read and Write together at MAR=7: Mdatain gets the old word.
        ctrl_if.mdr_in = 1'b1;
        applyStimulus();
        ctrl_if.write = 1'b1;
        ctrl_if.read  = 1'b1;
        applyStimulus();
        ctrl_if.md_read = 1'b1;
        ctrl_if.mdr_in  = 1'b1;
        applyStimulus();
        expectValue("rw_same_addr_old", 32'hDEAD_BEEF);
        ctrl_if.mdr_out = 1'b1;
        sampleBus();
        ctrl_if.read = 1'b1;
        applyStimulus();
        ctrl_if.md_read = 1'b1;
        ctrl_if.mdr_in  = 1'b1;
        applyStimulus();
        expectValue("rw_same_addr_new", 32'd0);
        ctrl_if.mdr_out = 1'b1;
        sampleBus();

        // Add with carry out.
        loadMdr(32'hFFFF_FFFF);
        ctrl_if.mdr_out = 1'b1;
        ctrl_if.y_in    = 1'b1;
        applyStimulus();
        loadMdr(32'd1);
        ctrl_if.mdr_out  = 1'b1;
        ctrl_if.op_add   = 1'b1;
        ctrl_if.zlow_in  = 1'b1;
        ctrl_if.zhigh_in = 1'b1;
        applyStimulus();
        expectValue("carry_zlow", 32'd0);
        ctrl_if.zlow_out = 1'b1;
        sampleBus();
        expectValue("carry_zhigh", 32'd1);
        checkOutput(dut.zhigh);

        // Zlow as both source and destination in the same cycle.
        ctrl_if.zlow_out = 1'b1;
        ctrl_if.inc_pc   = 1'b1;
        ctrl_if.zlow_in  = 1'b1;
        applyStimulus();
        ctrl_if.zlow_out = 1'b1;
        ctrl_if.inc_pc   = 1'b1;
        ctrl_if.zlow_in  = 1'b1;
        applyStimulus();
        expectValue("zlow_self_update", 32'd2);
        ctrl_if.zlow_out = 1'b1;
        sampleBus();

        // Sign extension and OR; Zhigh returns to 0 for non-ADD ops.
        loadMdr(32'h0007_FFFF);
        ctrl_if.mdr_out = 1'b1;
        ctrl_if.ir_in   = 1'b1;
        applyStimulus();
        expectValue("csign_negative", 32'hFFFF_FFFF);
        ctrl_if.csign_out = 1'b1;
        sampleBus();
        loadMdr(32'h0000_F0F0);
        ctrl_if.mdr_out = 1'b1;
        ctrl_if.y_in    = 1'b1;
        applyStimulus();
        loadMdr(32'h0F0F_0000);
        ctrl_if.mdr_out  = 1'b1;
        ctrl_if.op_or    = 1'b1;
        ctrl_if.zlow_in  = 1'b1;
        ctrl_if.zhigh_in = 1'b1;
        applyStimulus();
        expectValue("or_zlow", 32'h0F0F_F0F0);
        ctrl_if.zlow_out = 1'b1;
        sampleBus();
        expectValue("or_zhigh", 32'd0);
        checkOutput(dut.zhigh);

        // R0 is writable; Rout shows it, BAout forces 0 for index 0.
        loadMdr(32'hA5A5_A5A5);
        ctrl_if.mdr_out = 1'b1;
        ctrl_if.gra     = 1'b1;
        ctrl_if.r_in    = 1'b1;
        applyStimulus();
        expectValue("r0_rout", 32'hA5A5_A5A5);
        ctrl_if.gra   = 1'b1;
        ctrl_if.r_out = 1'b1;
        sampleBus();
        expectValue("r0_baout", 32'd0);
        ctrl_if.gra    = 1'b1;
        ctrl_if.ba_out = 1'b1;
        sampleBus();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
